// File: rtl/shift_defs.sv
// shift_defs: shared op/state encodings and default width for the shift/rotate sequencer
package shift_defs;
   localparam int DEFAULT_WIDTH = 32;
   typedef enum logic [2:0] {
      OP_SHL  = 3'd0,
      OP_SHR  = 3'd1,
      OP_SHRA = 3'd2,
      OP_ROL  = 3'd3,
      OP_ROR  = 3'd4
   } opT;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } stateT;
   function automatic logic isLegal(input logic [2:0] o);
      return o <= 3'(OP_ROR);
   endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit shift/rotate step (w -> w_next by op); illegal ops pass w through
module shift_step
   import shift_defs::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] w,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] w_next
);
   always_comb begin
      w_next = op == 3'(OP_SHL)  ? {w[WIDTH-2:0], 1'b0} :
               op == 3'(OP_SHR)  ? {1'b0, w[WIDTH-1:1]} :
               op == 3'(OP_SHRA) ? {w[WIDTH-1], w[WIDTH-1:1]} :
               op == 3'(OP_ROL)  ? {w[WIDTH-2:0], w[WIDTH-1]} :
               op == 3'(OP_ROR)  ? {w[0], w[WIDTH-1:1]} : w;
   end
endmodule

// File: rtl/shift_rotate_sequencer.sv
// shift_rotate_sequencer: multi-cycle shifter/rotator, one bit position per clock.
// Ports: clock/clear (async active-high), start/op/operand/amount request in,
// ready/busy/done/error status out, result held until the next accepted request.
module shift_rotate_sequencer
   import shift_defs::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int AMT_W = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic [AMT_W-1:0] amount,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] result
);
   stateT            state, nextState;
   logic [AMT_W-1:0] count;
   logic [WIDTH-1:0] work, stepped;
   logic [2:0]       opReg;
   logic             accept, lastStep;

   shift_step #(.WIDTH(WIDTH)) u_step (.w(work), .op(opReg), .w_next(stepped));

   always_comb begin
      accept   = state == ST_IDLE && start;
      lastStep = state == ST_RUN && count == AMT_W'(1);
      nextState = state == ST_IDLE ? (start ? ((isLegal(op) && amount != '0) ? ST_RUN : ST_DONE) : ST_IDLE) :
                  state == ST_RUN  ? (lastStep ? ST_DONE : ST_RUN) : ST_IDLE;
      ready = state == ST_IDLE;
      busy  = state == ST_RUN;
      done  = state == ST_DONE;
      error = state == ST_DONE && !isLegal(opReg);
   end

   // result is loaded only on entry to DONE, so it holds the previous value through RUN
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state  <= ST_IDLE;
         count  <= '0;
         work   <= '0;
         opReg  <= '0;
         result <= '0;
      end else begin
         state <= nextState;
         if (accept) begin
            work  <= operand;
            count <= amount;
            opReg <= op;
            if (nextState == ST_DONE) result <= operand;
         end else if (state == ST_RUN) begin
            work  <= stepped;
            count <= count - AMT_W'(1);
            if (lastStep) result <= stepped;
         end
      end
   end
endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// tb_shift_rotate_sequencer: table-driven, hand-sequenced and random checks of the shift/rotate sequencer
module tb_shift_rotate_sequencer;
   logic        clock = 0, clear = 1, start = 0;
   logic [2:0]  op = 0;
   logic [31:0] operand = 0;
   logic [4:0]  amount = 0;
   logic        ready, busy, done, error;
   logic [31:0] result;
   int          nCmp = 0, nBad = 0;
   logic [31:0] prevResult = 0;

   shift_rotate_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
      .clock(clock), .clear(clear), .start(start), .op(op), .operand(operand), .amount(amount),
      .ready(ready), .busy(busy), .done(done), .error(error), .result(result)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] x;
      logic [4:0]  a;
      logic [31:0] exp;
      bit          err;
      bit          junk;
   } vecT;
   vecT tbl[12];

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (!ok) begin
         nBad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] x, input int a);
      case (o)
         3'd0: return x << a;
         3'd1: return x >> a;
         3'd2: return 32'($signed(x) >>> a);
         3'd3: return a == 0 ? x : (x << a) | (x >> (32 - a));
         3'd4: return a == 0 ? x : (x >> a) | (x << (32 - a));
         default: return x;
      endcase
   endfunction

   task automatic runReq(input logic [2:0] o, input logic [31:0] x, input logic [4:0] a,
                         input logic [31:0] expRes, input bit expErr, input bit junk);
      int lat, k, busyCnt, w;
      bit holdOk, readyLow, seen;
      lat = o <= 3'd4 ? int'(a) : 0;
      w = 0;
      @(negedge clock);
      while (!ready && w < 5) begin
         @(negedge clock);
         w++;
      end
      check(ready, "ready_before_req", 32'(ready), 32'd1);
      op = o; operand = x; amount = a; start = 1;
      @(posedge clock);
      busyCnt = 0; holdOk = 1; readyLow = 1; seen = 0; k = 0;
      while (k < 40 && !seen) begin
         @(negedge clock);
         k++;
         if (done) seen = 1;
         else begin
            if (busy) busyCnt++;
            if (ready) readyLow = 0;
            if (result !== prevResult) holdOk = 0;
         end
         if (junk) begin
            start = 1; operand = $urandom; op = 3'($urandom); amount = 5'($urandom);
         end else start = 0;
      end
      check(seen, "done_timeout", 32'(seen), 32'd1);
      check(k == lat + 1, "latency", 32'(k), 32'(lat + 1));
      check(busyCnt == lat, "busy_cycles", 32'(busyCnt), 32'(lat));
      check(readyLow && holdOk, "ready_low_result_hold", {30'd0, readyLow, holdOk}, 32'd3);
      check(result === expRes, "result", result, expRes);
      check(error === expErr, "error", 32'(error), 32'(expErr));
      @(negedge clock);
      start = 0;
      check(ready === 1 && done === 0 && error === 0 && result === expRes, "after_done",
            {ready, done, error, result[28:0]}, {3'b100, expRes[28:0]});
      prevResult = expRes;
   endtask

   initial begin
      tbl[0]  = '{3'd3, 32'h80000001, 5'd1,  32'h00000003, 1'b0, 1'b0};
      tbl[1]  = '{3'd4, 32'h00000001, 5'd4,  32'h10000000, 1'b0, 1'b0};
      tbl[2]  = '{3'd4, 32'h12345678, 5'd31, 32'h2468ACF0, 1'b0, 1'b0};
      tbl[3]  = '{3'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0};
      tbl[4]  = '{3'd1, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
      tbl[5]  = '{3'd0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0};
      tbl[6]  = '{3'd6, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
      tbl[7]  = '{3'd7, 32'h0BADF00D, 5'd0,  32'h0BADF00D, 1'b1, 1'b0};
      tbl[8]  = '{3'd0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
      tbl[9]  = '{3'd3, 32'hF0000000, 5'd4,  32'h0000000F, 1'b0, 1'b0};
      tbl[10] = '{3'd2, 32'h40000000, 5'd30, 32'h00000001, 1'b0, 1'b0};
      tbl[11] = '{3'd0, 32'hA5A5A5A5, 5'd9,  32'h4B4B4A00, 1'b0, 1'b1};

      #12;
      check(ready === 1 && busy === 0 && done === 0 && error === 0, "reset_flags",
            {28'd0, ready, busy, done, error}, 32'h8);
      check(result === 0, "reset_result", result, 32'd0);
      @(negedge clock);
      clear = 0;

      for (int i = 0; i < 12; i++) runReq(tbl[i].op, tbl[i].x, tbl[i].a, tbl[i].exp, tbl[i].err, tbl[i].junk);

      begin
         bit sawDone;
         @(negedge clock);
         op = 3'd0; operand = 32'h12345678; amount = 5'd20; start = 1;
         @(posedge clock);
         start = 0;
         repeat (5) @(posedge clock);
         #2 clear = 1;
         #1;
         check(ready === 1 && busy === 0 && done === 0, "clear_flags", {29'd0, ready, busy, done}, 32'h4);
         check(result === 0, "clear_result", result, 32'd0);
         @(negedge clock);
         clear = 0;
         sawDone = 0;
         repeat (25) begin
            @(negedge clock);
            if (done) sawDone = 1;
         end
         check(!sawDone, "no_done_after_clear", 32'(sawDone), 32'd0);
         check(result === 0, "result_zero_after_clear", result, 32'd0);
         prevResult = 0;
      end
      runReq(3'd4, 32'h0000F00F, 5'd8, 32'h0F0000F0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  o;
         logic [31:0] x;
         logic [4:0]  a;
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         a = 5'($urandom_range(0, 31));
         runReq(o, x, a, refModel(o, x, int'(a)), o > 3'd4, i % 5 == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
